// File: rtl/wtu_pkg.sv
// Shared types for the wavelet transform unit controller and level wrappers.
// Holds the sequencer state encoding, the default data width and the result bundle.
package wtu_pkg;

    localparam int WTU_DATA_W = 24;

    typedef enum logic [2:0] {
        LOAD_A,
        LOAD_B,
        COMPUTE,
        WAIT,
        CAPTURE
    } wtu_state_e;

    typedef struct packed {
        logic [WTU_DATA_W-1:0] hpo;
        logic [WTU_DATA_W-1:0] lpo;
    } wtu_res_t;

endpackage

// File: rtl/wtu_out_reg.sv
// One-entry valid/ready holding register for the {hpo,lpo} result.
// o_can_load tells the producer a load this cycle will not overwrite unread data.
module wtu_out_reg #(
    parameter int W = 48
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_data,
    input  logic         i_ready,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    output logic         o_can_load
);

    logic         r_valid;
    logic [W-1:0] r_data;

    assign o_can_load = !r_valid || i_ready;
    assign o_valid    = r_valid;
    assign o_data     = r_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/wtu_ctrl.sv
// Sequencing controller for one wavelet transform unit: pairs samples, strobes, captures.
// Optional WTU_CTRL_STATS_EN adds a saturating stall_cnt of cycles stalled in CAPTURE.
module wtu_ctrl
    import wtu_pkg::*;
#(
    parameter int DATA_W   = WTU_DATA_W,
    parameter int UNIT_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    input  logic              flush,
    output logic [DATA_W-1:0] wtu_in,
    output logic              wtu_ld_a,
    output logic              wtu_ld_b,
    output logic              wtu_ld_o,
    input  logic [DATA_W-1:0] wtu_lpo,
    input  logic [DATA_W-1:0] wtu_hpo,
    output logic              m_valid,
    output logic [2*DATA_W-1:0] m_data,
    input  logic              m_ready,
    output logic [CNT_W-1:0]  pair_cnt
`ifdef WTU_CTRL_STATS_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    localparam int LW = $clog2(UNIT_LAT + 1);

    wtu_state_e        r_state;
    wtu_state_e        w_next;
    logic [DATA_W-1:0] r_a_hold;
    logic [LW-1:0]     r_wait;
    logic [CNT_W-1:0]  r_pair_cnt;
    logic              w_can_load;
    logic              w_capture;

    always_comb begin
        w_next    = r_state;
        s_ready   = 1'b0;
        wtu_in    = r_a_hold;
        wtu_ld_a  = 1'b0;
        wtu_ld_b  = 1'b0;
        wtu_ld_o  = 1'b0;
        w_capture = 1'b0;
        if (!rst) begin
            unique case (r_state)
                LOAD_A: begin
                    s_ready = 1'b1;
                    if (s_valid) begin
                        wtu_in   = s_data;
                        wtu_ld_a = 1'b1;
                        w_next   = LOAD_B;
                    end
                end
                LOAD_B: begin
                    s_ready = 1'b1;
                    // A real sample beats flush; flush stays pending
                    if (s_valid) begin
                        wtu_in   = s_data;
                        wtu_ld_b = 1'b1;
                        w_next   = COMPUTE;
                    end else if (flush) begin
                        wtu_ld_b = 1'b1;
                        w_next   = COMPUTE;
                    end
                end
                COMPUTE: begin
                    wtu_ld_o = 1'b1;
                    w_next   = WAIT;
                end
                WAIT: begin
                    if (r_wait == LW'(1)) begin
                        w_next = CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (w_can_load) begin
                        w_capture = 1'b1;
                        w_next    = LOAD_A;
                    end
                end
                default: w_next = LOAD_A;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= LOAD_A;
            r_a_hold   <= '0;
            r_wait     <= '0;
            r_pair_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (wtu_ld_a) begin
                r_a_hold <= s_data;
            end
            if (r_state == COMPUTE) begin
                r_wait <= LW'(UNIT_LAT);
            end else if (r_state == WAIT) begin
                r_wait <= r_wait - LW'(1);
            end
            if (w_capture) begin
                r_pair_cnt <= r_pair_cnt + CNT_W'(1);
            end
        end
    end

    assign pair_cnt = r_pair_cnt;

    wtu_out_reg #(
        .W(2 * DATA_W)
    ) u_out (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_capture),
        .i_data    ({wtu_hpo, wtu_lpo}),
        .i_ready   (m_ready),
        .o_valid   (m_valid),
        .o_data    (m_data),
        .o_can_load(w_can_load)
    );

`ifdef WTU_CTRL_STATS_EN
    logic [15:0] r_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall <= '0;
        end else if (r_state == CAPTURE && !w_can_load && r_stall != 16'hFFFF) begin
            r_stall <= r_stall + 16'd1;
        end
    end

    assign stall_cnt = r_stall;
`endif

endmodule

// File: tb/tb_wtu_ctrl.sv
// Directed bench for wtu_ctrl: cycle table plus stall, reset, latency-3 and wrap sequences.
module tb_wtu_ctrl;
    import wtu_pkg::*;

    logic        clk = 1'b0;
    logic        rst, s_valid, flush, m_ready;
    logic [23:0] s_data;
    logic        s_ready, ld_a, ld_b, ld_o, m_valid;
    logic [23:0] wtu_in, lpo, hpo;
    logic [47:0] m_data;
    logic [15:0] pair_cnt;

    logic        s_valid3, flush3, m_ready3;
    logic [23:0] s_data3;
    logic        s_ready3, ld_a3, ld_b3, ld_o3, m_valid3;
    logic [23:0] wtu_in3, lpo3, hpo3;
    logic [47:0] m_data3;
    logic [15:0] pair_cnt3;
`ifdef WTU_CTRL_STATS_EN
    logic [15:0] stall_cnt, stall_cnt3;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wtu_ctrl #(.DATA_W(24), .UNIT_LAT(1), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .flush(flush), .wtu_in(wtu_in),
        .wtu_ld_a(ld_a), .wtu_ld_b(ld_b), .wtu_ld_o(ld_o),
        .wtu_lpo(lpo), .wtu_hpo(hpo), .m_valid(m_valid),
        .m_data(m_data), .m_ready(m_ready), .pair_cnt(pair_cnt)
`ifdef WTU_CTRL_STATS_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    wtu_ctrl #(.DATA_W(24), .UNIT_LAT(3), .CNT_W(16)) dut3 (
        .clk(clk), .rst(rst), .s_valid(s_valid3), .s_data(s_data3),
        .s_ready(s_ready3), .flush(flush3), .wtu_in(wtu_in3),
        .wtu_ld_a(ld_a3), .wtu_ld_b(ld_b3), .wtu_ld_o(ld_o3),
        .wtu_lpo(lpo3), .wtu_hpo(hpo3), .m_valid(m_valid3),
        .m_data(m_data3), .m_ready(m_ready3), .pair_cnt(pair_cnt3)
`ifdef WTU_CTRL_STATS_EN
        , .stall_cnt(stall_cnt3)
`endif
    );

    // Unit model, latency 1: lpo=a+b, hpo=a-b, outputs held until next ld_o
    logic [23:0] ua, ub;
    always_ff @(posedge clk) begin
        if (ld_a) ua <= wtu_in;
        if (ld_b) ub <= wtu_in;
        if (ld_o) begin
            lpo <= ua + ub;
            hpo <= ua - ub;
        end
    end

    // Unit model, latency 3: result walks a 3-deep delay line
    logic [23:0] u3a, u3b;
    logic [47:0] q0, q1, q2;
    always_ff @(posedge clk) begin
        if (ld_a3) u3a <= wtu_in3;
        if (ld_b3) u3b <= wtu_in3;
        if (ld_o3) q0 <= {u3a - u3b, u3a + u3b};
        q1 <= q0;
        q2 <= q1;
    end
    assign lpo3 = q2[23:0];
    assign hpo3 = q2[47:24];

    typedef struct packed {
        logic        rst;
        logic        sv;
        logic [23:0] sd;
        logic        fl;
    } vin_t;

    typedef struct packed {
        logic        sr;
        logic        la;
        logic        lb;
        logic        lo;
        logic [23:0] wi;
        logic        mv;
        logic [47:0] md;
        logic [15:0] pc;
    } vout_t;

    typedef struct packed {
        vin_t  i;
        vout_t o;
    } vec_t;

    function automatic vec_t mkv(
        input logic r, input logic sv, input logic [23:0] sd, input logic fl,
        input logic [3:0] strb, input logic [23:0] wi, input logic mv,
        input logic [23:0] mh, input logic [23:0] ml, input logic [15:0] pc);
        vec_t v;
        v.i = '{rst: r, sv: sv, sd: sd, fl: fl};
        v.o = '{sr: strb[3], la: strb[2], lb: strb[1], lo: strb[0],
                wi: wi, mv: mv, md: {mh, ml}, pc: pc};
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [23:0] d);
        int n;
        s_valid = 1'b1;
        s_data  = d;
        n = 0;
        #1;
        while (!s_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL send_timeout got %0d exp <200", n);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic wait_mv(input string nm);
        int n;
        n = 0;
        @(negedge clk);
        while (!m_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout got %0d exp <50", nm, n);
        end
    endtask

    vec_t vt[18];
    logic [47:0] exp_res[4];

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_data = '0; flush = 1'b0; m_ready = 1'b1;
        s_valid3 = 1'b0; s_data3 = '0; flush3 = 1'b0; m_ready3 = 1'b1;

        vt[0]  = mkv(1, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0);
        vt[1]  = mkv(0, 1, 5, 0, 4'b1100, 5, 0, 0, 0, 0);
        vt[2]  = mkv(0, 1, 3, 0, 4'b1010, 3, 0, 0, 0, 0);
        vt[3]  = mkv(0, 0, 0, 0, 4'b0001, 5, 0, 0, 0, 0);
        vt[4]  = mkv(0, 0, 0, 0, 4'b0000, 5, 0, 0, 0, 0);
        vt[5]  = mkv(0, 0, 0, 0, 4'b0000, 5, 0, 0, 0, 0);
        vt[6]  = mkv(0, 1, 7, 0, 4'b1100, 7, 1, 2, 8, 1);
        vt[7]  = mkv(0, 0, 0, 1, 4'b1010, 7, 0, 2, 8, 1);
        vt[8]  = mkv(0, 0, 0, 0, 4'b0001, 7, 0, 2, 8, 1);
        vt[9]  = mkv(0, 0, 0, 0, 4'b0000, 7, 0, 2, 8, 1);
        vt[10] = mkv(0, 0, 0, 0, 4'b0000, 7, 0, 2, 8, 1);
        vt[11] = mkv(0, 1, 4, 0, 4'b1100, 4, 1, 0, 14, 2);
        vt[12] = mkv(0, 1, 9, 1, 4'b1010, 9, 0, 0, 14, 2);
        vt[13] = mkv(0, 0, 0, 0, 4'b0001, 4, 0, 0, 14, 2);
        vt[14] = mkv(0, 0, 0, 0, 4'b0000, 4, 0, 0, 14, 2);
        vt[15] = mkv(0, 0, 0, 0, 4'b0000, 4, 0, 0, 14, 2);
        vt[16] = mkv(0, 0, 0, 1, 4'b1000, 4, 1, 24'hFFFFFB, 13, 3);
        vt[17] = mkv(0, 0, 0, 0, 4'b1000, 4, 0, 24'hFFFFFB, 13, 3);

        @(posedge clk);
        #1;
        for (int i = 0; i < 18; i++) begin
            rst = vt[i].i.rst; s_valid = vt[i].i.sv;
            s_data = vt[i].i.sd; flush = vt[i].i.fl;
            @(negedge clk);
            checks++;
            if ({s_ready, ld_a, ld_b, ld_o, wtu_in, m_valid, m_data, pair_cnt}
                !== vt[i].o) begin
                errors++;
                $display("FAIL vec%0d got %h exp %h", i,
                    {s_ready, ld_a, ld_b, ld_o, wtu_in, m_valid, m_data, pair_cnt},
                    vt[i].o);
            end
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0; flush = 1'b0;

        // Reset during WAIT discards the pair in flight
        send(24'd1);
        send(24'd2);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mvalid", 64'(m_valid), 64'd0);
        chk("rst_paircnt", 64'(pair_cnt), 64'd0);
        chk("rst_state", 64'(dut.r_state), 64'(LOAD_A));
        chk("rst_sready", 64'(s_ready), 64'd1);
        @(posedge clk);
        #1;
        send(24'd1);
        send(24'd1);
        wait_mv("rst_pair");
        chk("rst_pair_data", 64'(m_data), 64'({24'd0, 24'd2}));
        chk("rst_pair_cnt", 64'(pair_cnt), 64'd1);

        // Back-pressure: four pairs with m_ready low, then drain
        @(posedge clk);
        #1;
        rst = 1'b1;
        m_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            exp_res[k] = {24'(10 * (k + 1)) - 24'(k + 1), 24'(10 * (k + 1)) + 24'(k + 1)};
        end
        fork
            begin
                for (int k = 1; k <= 4; k++) begin
                    send(24'(10 * k));
                    send(24'(k));
                end
            end
            begin
                int got;
                got = 0;
                repeat (40) @(negedge clk);
                chk("stall_mvalid", 64'(m_valid), 64'd1);
                chk("stall_data", 64'(m_data), 64'(exp_res[0]));
                chk("stall_sready", 64'(s_ready), 64'd0);
                chk("stall_state", 64'(dut.r_state), 64'(CAPTURE));
`ifdef WTU_CTRL_STATS_EN
                chk("stall_cnt_nz", 64'(stall_cnt != 16'd0), 64'd1);
`endif
                @(negedge clk);
                chk("stall_hold", 64'(m_data), 64'(exp_res[0]));
                @(posedge clk);
                #1;
                m_ready = 1'b1;
                for (int c = 0; c < 80 && got < 4; c++) begin
                    @(negedge clk);
                    if (m_valid) begin
                        chk($sformatf("drain%0d", got), 64'(m_data), 64'(exp_res[got]));
                        got++;
                    end
                end
                chk("drain_count", 64'(got), 64'd4);
            end
        join
        @(negedge clk);
        chk("drain_paircnt", 64'(pair_cnt), 64'd4);

        // Latency-3 instance: m_valid exactly 6 cycles after the B handshake
        @(posedge clk);
        #1;
        s_valid3 = 1'b1;
        s_data3 = 24'd100;
        @(posedge clk);
        #1;
        s_data3 = 24'd50;
        @(posedge clk);
        #1;
        s_valid3 = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            chk($sformatf("lat3_c%0d", i), 64'(m_valid3), 64'(i == 6));
            if (i == 1) chk("lat3_sready", 64'(s_ready3), 64'd0);
            if (i < 6) @(posedge clk);
        end
        chk("lat3_data", 64'(m_data3), 64'({24'd50, 24'd150}));
        chk("lat3_cnt", 64'(pair_cnt3), 64'd1);

        // Preload pair_cnt to all-ones and confirm the wrap
        @(posedge clk);
        #1;
        force dut3.r_pair_cnt = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut3.r_pair_cnt;
        @(negedge clk);
        chk("wrap_preload", 64'(pair_cnt3), 64'hFFFF);
        @(posedge clk);
        #1;
        s_valid3 = 1'b1;
        s_data3 = 24'd2;
        @(posedge clk);
        #1;
        s_data3 = 24'd1;
        @(posedge clk);
        #1;
        s_valid3 = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("wrap_mvalid", 64'(m_valid3), 64'd1);
        chk("wrap_data", 64'(m_data3), 64'({24'd1, 24'd3}));
        chk("wrap_cnt", 64'(pair_cnt3), 64'd0);
`ifdef WTU_CTRL_STATS_EN
        chk("lat3_stall_zero", 64'(stall_cnt3), 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wtu_ctrl.md
Name: wtu_ctrl

Overview:
Sequencing controller for one wavelet transform unit (wtu_unit: 24-bit sample in, ld_a/ld_b/ld_o strobes, 24-bit lpo/hpo results).
- Accepts a valid/ready sample stream and pairs consecutive samples as A then B.
- Strobes the unit, waits its result latency, and buffers {hpo,lpo} in a one-entry output register with a valid/ready handshake.
- Sits between the sample source and downstream level logic; replaces hand-driven strobes in the wtu level wrappers.

Parameters:
DATA_W, 24, sample and half-result width
UNIT_LAT, 1, cycles from the ld_o edge to lpo/hpo valid at the unit outputs; legal range is >= 1
CNT_W, 16, width of pair_cnt

Ports:
clk  in  1  clock; all logic is rising-edge
rst  in  1  synchronous, active-high reset
s_valid  in  1  input sample valid
s_data  in  DATA_W  input sample
s_ready  out  1  controller accepts a sample this cycle
flush  in  1  end of stream; completes an odd trailing A by duplicating it as B
wtu_in  out  DATA_W  sample bus to the unit
wtu_ld_a  out  1  load-A strobe
wtu_ld_b  out  1  load-B strobe
wtu_ld_o  out  1  compute/load-output strobe
wtu_lpo  in  DATA_W  unit low-pass result
wtu_hpo  in  DATA_W  unit high-pass result
m_valid  out  1  result valid
m_data  out  2*DATA_W  {hpo,lpo}
m_ready  in  1  downstream accepts the result
pair_cnt  out  CNT_W  captured-pair count; wraps modulo 2^CNT_W

Behaviour:
Reset:
- rst is synchronous and active-high and aborts any pair in flight; the partial pair is discarded.
- Reset values: state=LOAD_A, m_valid=0, m_data=0, pair_cnt=0, a_hold=0, wait counter=0.
- s_ready is forced 0 in any cycle where rst=1; all strobes are 0.

FSM states: LOAD_A, LOAD_B, COMPUTE, WAIT, CAPTURE.
- LOAD_A: s_ready=1. On handshake: wtu_in=s_data, wtu_ld_a=1, a_hold<=s_data, go to LOAD_B. flush is ignored here.
- LOAD_B: s_ready=1.
  - On handshake: wtu_in=s_data, wtu_ld_b=1, go to COMPUTE.
  - Else if flush=1: wtu_in=a_hold, wtu_ld_b=1, go to COMPUTE.
  - If s_valid and flush are both high, the sample wins and flush is not consumed.
- COMPUTE: wtu_ld_o=1 for exactly one cycle; load wait counter with UNIT_LAT; go to WAIT.
- WAIT: decrement the counter; when it reaches 1, go to CAPTURE. WAIT lasts exactly UNIT_LAT cycles.
- CAPTURE: if m_valid=0, or m_valid&m_ready this cycle:
  - m_data<={wtu_hpo,wtu_lpo}, m_valid<=1, pair_cnt<=pair_cnt+1, go to LOAD_A.
  - Otherwise stall in CAPTURE. The unit holds its outputs, so a stall loses no data.
- In states other than LOAD_A/LOAD_B: s_ready=0 and wtu_in=a_hold. At most one strobe is high per cycle.

Output register:
- m_valid clears on m_valid&m_ready unless reloaded in the same cycle.
- m_data is stable while m_valid=1 and m_ready=0.

Latency and throughput:
- B handshake at cycle t: ld_o at t+1, capture at t+2+UNIT_LAT, m_valid visible at t+3+UNIT_LAT (t+4 for UNIT_LAT=1).
- Peak throughput: one pair per 4+UNIT_LAT cycles.
- The next pair's A/B may load while the previous result waits in the output register.

Optional Feature:
WTU_CTRL_STATS_EN
- Defined: adds output stall_cnt [15:0]. It increments every cycle spent in CAPTURE without capturing, saturates at 16'hFFFF, and resets to 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package wtu_pkg holds:
  - the state enum typedef (LOAD_A, LOAD_B, COMPUTE, WAIT, CAPTURE)
  - the DATA_W default
  - the result struct {hpo,lpo}, shared with the level wrappers
- One natural sub-module: wtu_out_reg, the one-entry valid/ready holding register with its load/stall logic.
- FSM, counters and a_hold stay in wtu_ctrl.

Test Plan:
Bench uses a unit model with lpo=a+b, hpo=a-b (mod 2^24) and UNIT_LAT=1 unless stated.
1. Samples 5,3 with m_ready=1 -> ld_a with 5, ld_b with 3, ld_o one cycle later; m_data={24'd2,24'd8} with m_valid 4 cycles after the B handshake; pair_cnt=1.
2. Sample 7 then flush=1 (s_valid=0) -> ld_b with wtu_in=7; m_data={0,14}.
3. Four pairs with m_ready held 0 -> first result held stable; FSM stalls in CAPTURE with s_ready=0 after the second pair loads. Release m_ready -> all four results arrive in order; pair_cnt=4; with the macro, stall_cnt is non-zero.
4. Assert rst for 1 cycle during WAIT -> m_valid=0, pair_cnt=0, state LOAD_A; the next pair 1,1 yields {0,2}.
5. s_valid and flush both high in LOAD_B with s_data=9 after A=4 -> B=9, not 4; result {-5 mod 2^24,13}.
6. UNIT_LAT=3 build -> m_valid exactly 6 cycles after the B handshake; pair_cnt wraps from 16'hFFFF to 0 after preloading by forcing.
